lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/core_pkg.sv | 44 ++++
 rtl/lsu_align.sv | 74 +++++++
 rtl/lsu.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: RV32I load/store size codes, the LSU state
// encoding and the size/misalignment helpers used by the LSU.
package core_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } lsu_size_t;

  // Undefined funct3 codes fall through to word accesses.
  function automatic lsu_size_t size_of(input logic [2:0] f3);
    lsu_size_t sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    case (size_of(f3))
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = lo[0];
      default: mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the LSU: store byte enables and data replication,
// load lane extraction with sign/zero extension.
module lsu_align
  import core_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic        sign_s;

  // Store side: lane enables and replicated write data.
  always_comb begin
    st_be        = 4'b1111;
    st_wdata_rep = st_wdata;
    case (size_of(st_funct3))
      SZ_B: begin
        case (st_addr_lo)
          2'b00:   st_be = 4'b0001;
          2'b01:   st_be = 4'b0010;
          2'b10:   st_be = 4'b0100;
          default: st_be = 4'b1000;
        endcase
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      SZ_H: begin
        if (st_addr_lo[1]) begin
          st_be = 4'b1100;
        end else begin
          st_be = 4'b0011;
        end
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      default: begin
        st_be        = 4'b1111;
        st_wdata_rep = st_wdata;
      end
    endcase
  end

  // Load side: pick the addressed lane, then extend (funct3[2] marks unsigned).
  always_comb begin
    byte_s  = 8'h00;
    half_s  = 16'h0000;
    sign_s  = ~ld_funct3[2];
    ld_data = ld_word;
    case (ld_addr_lo)
      2'b00:   byte_s = ld_word[7:0];
      2'b01:   byte_s = ld_word[15:8];
      2'b10:   byte_s = ld_word[23:16];
      default: byte_s = ld_word[31:24];
    endcase
    if (ld_addr_lo[1]) begin
      half_s = ld_word[31:16];
    end else begin
      half_s = ld_word[15:0];
    end
    case (size_of(ld_funct3))
      SZ_B:    ld_data = {{24{sign_s & byte_s[7]}}, byte_s};
      SZ_H:    ld_data = {{16{sign_s & half_s[15]}}, half_s};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: IDLE/REQ/WAIT handshake FSM with registered memory
// interface. Define LSU_MISALIGN_CHECK_EN to trap misaligned accesses locally.
module lsu
  import core_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        load_i,
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  lsu_state_t  state_r, state_nxt_s;
  logic        accept_s, mis_s, done_nxt_s, mis_nxt_s;
  logic        is_load_r, we_r, done_r, misaligned_r;
  logic [2:0]  funct3_r;
  logic [31:0] addr_r, wdata_r, rdata_r;
  logic [3:0]  be_r;
  logic [3:0]  be_s;
  logic [31:0] wdata_rep_s, rdata_ext_s;

  assign accept_s = valid_i && (state_r == IDLE) && (load_i ^ store_i);

`ifdef LSU_MISALIGN_CHECK_EN
  assign mis_s = misaligned(funct3_i, addr_i[1:0]);
`else
  assign mis_s = 1'b0;
`endif

  lsu_align u_align (
    .st_funct3    (funct3_i),
    .st_addr_lo   (addr_i[1:0]),
    .st_wdata     (wdata_i),
    .st_be        (be_s),
    .st_wdata_rep (wdata_rep_s),
    .ld_funct3    (funct3_r),
    .ld_addr_lo   (addr_r[1:0]),
    .ld_word      (mem_rdata_i),
    .ld_data      (rdata_ext_s)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !mis_s) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          state_nxt_s = is_load_r ? WAIT : IDLE;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Completion pulses for the following cycle.
  always_comb begin
    done_nxt_s = 1'b0;
    mis_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        done_nxt_s = accept_s && mis_s;
        mis_nxt_s  = accept_s && mis_s;
      end
      REQ:     done_nxt_s = mem_gnt_i && !is_load_r;
      WAIT:    done_nxt_s = mem_rvalid_i;
      default: done_nxt_s = 1'b0;
    endcase
  end

  // Operation capture, load result and output pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      is_load_r    <= 1'b0;
      we_r         <= 1'b0;
      funct3_r     <= 3'b000;
      addr_r       <= 32'h0000_0000;
      be_r         <= 4'b0000;
      wdata_r      <= 32'h0000_0000;
      rdata_r      <= 32'h0000_0000;
      done_r       <= 1'b0;
      misaligned_r <= 1'b0;
    end else begin
      if (accept_s) begin
        is_load_r <= load_i;
        we_r      <= store_i;
        funct3_r  <= funct3_i;
        addr_r    <= addr_i;
        be_r      <= be_s;
        wdata_r   <= wdata_rep_s;
      end
      if ((state_r == WAIT) && mem_rvalid_i) begin
        rdata_r <= rdata_ext_s;
      end
      done_r       <= done_nxt_s;
      misaligned_r <= mis_nxt_s;
    end
  end

  assign ready_o      = (state_r == IDLE);
  assign done_o       = done_r;
  assign misaligned_o = misaligned_r;
  assign rdata_o      = rdata_r;
  assign mem_req_o    = (state_r == REQ);
  assign mem_we_o     = we_r;
  assign mem_addr_o   = {addr_r[31:2], 2'b00};
  assign mem_be_o     = be_r;
  assign mem_wdata_o  = wdata_r;

endmodule
